clk_rst_seq: RTL and testbench



---
 rtl/clk_rst_seq_if.sv | 26 ++
 rtl/clk_rst_seq.sv | 175 +++++++++++++++++
 tb/tb_clk_rst_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_rst_seq_if.sv
// Bundles the MMCM lock/restart inputs and the sequenced reset/status outputs.
// The master modport is the sequencer side; the slave modport is the consumer side.
interface clk_rst_seq_if #(
   parameter int N_CH        = 3,
   parameter int MAX_RETRIES = 3
);
   localparam int RW = $clog2(MAX_RETRIES + 1);

   logic            i_locked;
   logic            i_restart;
   logic            o_pll_reset;
   logic [N_CH-1:0] o_ch_reset;
   logic            o_ready;
   logic            o_fault;
   logic [RW-1:0]   o_retry_count;

   modport master (
      input  i_locked, i_restart,
      output o_pll_reset, o_ch_reset, o_ready, o_fault, o_retry_count
   );

   modport slave (
      output i_locked, i_restart,
      input  o_pll_reset, o_ch_reset, o_ready, o_fault, o_retry_count
   );
endinterface

// File: rtl/clk_rst_seq.sv
// MMCM bring-up sequencer: reset pulse, filtered lock wait, staggered channel release, retry/fault.
// Optional macro CLK_RST_SEQ_AUTORECOVER_EN: lock loss in RUN restarts bring-up instead of faulting.
module clk_rst_seq #(
   parameter int N_CH                = 3,
   parameter int PLL_RST_CYCLES      = 8,
   parameter int LOCK_FILTER_CYCLES  = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1000,
   parameter int CH_STAGGER_CYCLES   = 4,
   parameter int MAX_RETRIES         = 3
) (
   input  logic          i_clk,
   input  logic          i_reset,
   clk_rst_seq_if.master io_seq
);
   localparam int RW        = $clog2(MAX_RETRIES + 1);
   localparam int REL_LAST  = (N_CH - 1) * CH_STAGGER_CYCLES;
   localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > REL_LAST) ? CNT_MAX_A : REL_LAST;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int FLT_W     = $clog2(LOCK_FILTER_CYCLES + 1);

   localparam logic [CNT_W-1:0] C_PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_TMO       = CNT_W'(LOCK_TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] C_REL_LAST  = CNT_W'(REL_LAST);
   localparam logic [FLT_W-1:0] C_FLT       = FLT_W'(LOCK_FILTER_CYCLES);
   localparam logic [RW-1:0]    C_RETRY_MAX = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_RELEASE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [FLT_W-1:0]  r_flt;
   logic [RW-1:0]     r_retry;
   logic              r_pll_reset;
   logic [N_CH-1:0]   r_ch;
   logic              r_ready;
   logic              r_fault;
   logic              r_lock_meta;
   logic              r_lock_s;

   logic [CNT_W-1:0]  w_cnt_inc;
   logic [FLT_W-1:0]  w_flt_inc;
   logic [RW-1:0]     w_retry_inc;
   logic              w_retry_last;
   logic [N_CH-1:0]   w_rel_hit;

   assign w_cnt_inc    = r_cnt + CNT_W'(1);
   assign w_flt_inc    = r_flt + FLT_W'(1);
   assign w_retry_inc  = r_retry + RW'(1);
   assign w_retry_last = (w_retry_inc == C_RETRY_MAX);

   // Channel k drops on the cycle the stagger counter lands on k*CH_STAGGER_CYCLES.
   for (genvar k = 0; k < N_CH; k++) begin : g_rel
      assign w_rel_hit[k] = (k == 0) ? 1'b0 : (w_cnt_inc == CNT_W'(k * CH_STAGGER_CYCLES));
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= io_seq.i_locked;
         r_lock_s    <= r_lock_meta;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_PLL_RST;
         r_cnt       <= '0;
         r_flt       <= '0;
         r_retry     <= '0;
         r_pll_reset <= 1'b1;
         r_ch        <= '1;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else if (io_seq.i_restart) begin
         r_state     <= S_PLL_RST;
         r_cnt       <= '0;
         r_flt       <= '0;
         r_retry     <= '0;
         r_pll_reset <= 1'b1;
         r_ch        <= '1;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         case (r_state)
            S_PLL_RST: begin
               if (r_cnt == C_PLL_LAST) begin
                  r_state     <= S_WAIT_LOCK;
                  r_cnt       <= '0;
                  r_flt       <= '0;
                  r_pll_reset <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_WAIT_LOCK: begin
               // Filter completion beats a coincident timeout.
               if (r_lock_s && (w_flt_inc == C_FLT)) begin
                  r_state <= S_RELEASE;
                  r_cnt   <= '0;
                  r_flt   <= '0;
                  r_ch[0] <= 1'b0;
               end else if (w_cnt_inc == C_TMO) begin
                  r_state     <= w_retry_last ? S_FAULT : S_PLL_RST;
                  r_fault     <= w_retry_last;
                  r_retry     <= w_retry_inc;
                  r_cnt       <= '0;
                  r_flt       <= '0;
                  r_pll_reset <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
                  r_flt <= r_lock_s ? w_flt_inc : '0;
               end
            end
            S_RELEASE: begin
               if (!r_lock_s) begin
                  r_state     <= w_retry_last ? S_FAULT : S_PLL_RST;
                  r_fault     <= w_retry_last;
                  r_retry     <= w_retry_inc;
                  r_cnt       <= '0;
                  r_pll_reset <= 1'b1;
                  r_ch        <= '1;
               end else if (r_cnt == C_REL_LAST) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
                  r_ch  <= r_ch & ~w_rel_hit;
               end
            end
            S_RUN: begin
               if (!r_lock_s) begin
                  r_ch        <= '1;
                  r_ready     <= 1'b0;
                  r_pll_reset <= 1'b1;
                  r_cnt       <= '0;
`ifdef CLK_RST_SEQ_AUTORECOVER_EN
                  r_state     <= S_PLL_RST;
                  r_retry     <= '0;
`else
                  r_state     <= S_FAULT;
                  r_fault     <= 1'b1;
`endif
               end
            end
            S_FAULT: begin
               r_pll_reset <= 1'b1;
               r_ch        <= '1;
               r_fault     <= 1'b1;
            end
            default: begin
               r_state     <= S_PLL_RST;
               r_cnt       <= '0;
               r_pll_reset <= 1'b1;
               r_ch        <= '1;
               r_ready     <= 1'b0;
            end
         endcase
      end
   end

   assign io_seq.o_pll_reset   = r_pll_reset;
   assign io_seq.o_ch_reset    = r_ch;
   assign io_seq.o_ready       = r_ready;
   assign io_seq.o_fault       = r_fault;
   assign io_seq.o_retry_count = r_retry;
endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq: expected output vectors are queued with their due cycle
// when stimulus is driven, then popped and compared as the cycle counter reaches them.
module tb_clk_rst_seq;
   localparam int N_CH        = 3;
   localparam int MAX_RETRIES = 3;

   typedef struct {
      int         due;
      logic [7:0] exp;
      string      tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t q[$];
   int   cyc;
   int   checks;
   int   failures;

   always #5 clk = ~clk;

   clk_rst_seq_if #(.N_CH(N_CH), .MAX_RETRIES(MAX_RETRIES)) u_if ();

   clk_rst_seq #(
      .N_CH(N_CH), .PLL_RST_CYCLES(8), .LOCK_FILTER_CYCLES(16),
      .LOCK_TIMEOUT_CYCLES(1000), .CH_STAGGER_CYCLES(4), .MAX_RETRIES(MAX_RETRIES)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .io_seq(u_if.master)
   );

   // {pll_reset, ch_reset[2:0], ready, fault, retry_count[1:0]}
   function automatic logic [7:0] vec(input logic pll, input logic [2:0] ch,
                                      input logic rdy, input logic flt, input logic [1:0] rc);
      return {pll, ch, rdy, flt, rc};
   endfunction

   function automatic logic [7:0] obs();
      return {u_if.o_pll_reset, u_if.o_ch_reset, u_if.o_ready, u_if.o_fault, u_if.o_retry_count};
   endfunction

   task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, o, e, cyc);
      end
   endtask

   task automatic push(input int due, input logic [7:0] e, input string tag);
      exp_t x;
      int   i;
      x.due = due;
      x.exp = e;
      x.tag = tag;
      i = 0;
      while (i < q.size() && q[i].due <= due) i++;
      q.insert(i, x);
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
         x = q.pop_front();
         check(x.tag, obs(), x.exp);
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, r, f, g, a, h;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst      = 1'b1;
      u_if.i_locked  = 1'b0;
      u_if.i_restart = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", obs(), vec(1, 3'b111, 0, 0, 2'd0));
      rst = 1'b0;
      cyc = 0;

      // First bring-up: 8-cycle PLL reset, lock 10 cycles after it ends.
      push(7, vec(1, 3'b111, 0, 0, 0), "pll_hi_last");
      push(8, vec(0, 3'b111, 0, 0, 0), "pll_lo");
      t = 18;
      run_to(t);
      u_if.i_locked = 1'b1;
      push(t + 17, vec(0, 3'b111, 0, 0, 0), "pre_release");
      push(t + 18, vec(0, 3'b110, 0, 0, 0), "ch0_rel");
      push(t + 21, vec(0, 3'b110, 0, 0, 0), "ch1_hold");
      push(t + 22, vec(0, 3'b100, 0, 0, 0), "ch1_rel");
      push(t + 25, vec(0, 3'b100, 0, 0, 0), "ch2_hold");
      push(t + 26, vec(0, 3'b000, 0, 0, 0), "ch2_rel");
      push(t + 27, vec(0, 3'b000, 1, 0, 0), "ready");

      // One-cycle lock drop in RUN.
      run_to(50);
      u_if.i_locked = 1'b0;
      push(52, vec(0, 3'b000, 1, 0, 0), "run_hold");
`ifdef CLK_RST_SEQ_AUTORECOVER_EN
      push(53, vec(1, 3'b111, 0, 0, 0), "lockloss");
      push(60, vec(1, 3'b111, 0, 0, 0), "recover_pll_hi");
      push(61, vec(0, 3'b111, 0, 0, 0), "recover_pll_lo");
`else
      push(53, vec(1, 3'b111, 0, 1, 0), "lockloss");
      push(60, vec(1, 3'b111, 0, 1, 0), "lockloss_fault_hold");
      push(61, vec(1, 3'b111, 0, 1, 0), "lockloss_fault_hold2");
`endif
      tick();
      u_if.i_locked = 1'b1;

      // Restart with lock held low: three timeouts then FAULT.
      r = 70;
      run_to(r);
      u_if.i_restart = 1'b1;
      u_if.i_locked  = 1'b0;
      push(r + 1,    vec(1, 3'b111, 0, 0, 0), "restart");
      push(r + 8,    vec(1, 3'b111, 0, 0, 0), "a1_pll_hi");
      push(r + 9,    vec(0, 3'b111, 0, 0, 0), "a1_pll_lo");
      push(r + 1008, vec(0, 3'b111, 0, 0, 0), "a1_wait_end");
      push(r + 1009, vec(1, 3'b111, 0, 0, 1), "timeout1");
      push(r + 1016, vec(1, 3'b111, 0, 0, 1), "a2_pll_hi");
      push(r + 1017, vec(0, 3'b111, 0, 0, 1), "a2_pll_lo");
      push(r + 2016, vec(0, 3'b111, 0, 0, 1), "a2_wait_end");
      push(r + 2017, vec(1, 3'b111, 0, 0, 2), "timeout2");
      push(r + 2025, vec(0, 3'b111, 0, 0, 2), "a3_pll_lo");
      push(r + 3024, vec(0, 3'b111, 0, 0, 2), "a3_wait_end");
      push(r + 3025, vec(1, 3'b111, 0, 1, 3), "fault");
      push(r + 3030, vec(1, 3'b111, 0, 1, 3), "fault_hold");
      tick();
      u_if.i_restart = 1'b0;

      // Restart out of FAULT, then restart coincident with the final timeout.
      f = r + 3030;
      run_to(f);
      u_if.i_restart = 1'b1;
      push(f + 1,    vec(1, 3'b111, 0, 0, 0), "restart_from_fault");
      push(f + 8,    vec(1, 3'b111, 0, 0, 0), "rf_pll_hi");
      push(f + 9,    vec(0, 3'b111, 0, 0, 0), "rf_pll_lo");
      push(f + 3024, vec(0, 3'b111, 0, 0, 2), "pre_final_timeout");
      tick();
      u_if.i_restart = 1'b0;
      run_to(f + 3024);
      u_if.i_restart = 1'b1;
      push(f + 3025, vec(1, 3'b111, 0, 0, 0), "restart_vs_timeout");
      push(f + 3032, vec(1, 3'b111, 0, 0, 0), "rvt_pll_hi");
      push(f + 3033, vec(0, 3'b111, 0, 0, 0), "rvt_pll_lo");
      tick();
      u_if.i_restart = 1'b0;

      // Lock glitch: 10 high, 1 low, then steady high.
      g = f + 3025;
      a = g + 10;
      run_to(a);
      u_if.i_locked = 1'b1;
      push(a + 20, vec(0, 3'b111, 0, 0, 0), "glitch_no_rel");
      push(a + 28, vec(0, 3'b111, 0, 0, 0), "glitch_pre_rel");
      push(a + 29, vec(0, 3'b110, 0, 0, 0), "glitch_rel");
      push(a + 37, vec(0, 3'b000, 0, 0, 0), "glitch_ch2");
      push(a + 38, vec(0, 3'b000, 1, 0, 0), "glitch_ready");
      run_to(a + 10);
      u_if.i_locked = 1'b0;
      tick();
      u_if.i_locked = 1'b1;

      // Async reset in the middle of RELEASE.
      h = a + 45;
      run_to(h);
      u_if.i_restart = 1'b1;
      push(h + 1,  vec(1, 3'b111, 0, 0, 0), "restart_locked");
      push(h + 9,  vec(0, 3'b111, 0, 0, 0), "rl_pll_lo");
      push(h + 24, vec(0, 3'b111, 0, 0, 0), "rl_pre_rel");
      push(h + 25, vec(0, 3'b110, 0, 0, 0), "rl_ch0_rel");
      push(h + 27, vec(0, 3'b110, 0, 0, 0), "rl_mid_release");
      tick();
      u_if.i_restart = 1'b0;
      run_to(h + 27);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", obs(), vec(1, 3'b111, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      push(3, vec(1, 3'b111, 0, 0, 0), "post_reset");
      run_to(3);

      check("sb_empty", 8'(q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
